uart_tx_queue: RTL and testbench

Upstream feeder for the UART transmitter in the FPGA top level. Debounces the active-low board button and, on each debounced release, captures the 8-bit switch value into a small FIFO. Drains the FIFO into the transmitter one byte at a time using the transmitter's launch/active/done handshake. Presses made while a byte is on the line are queued, not lost.

---
 rtl/uart_tx_queue.sv | 159 +++++++++++++++
 tb/tb_uart_tx_queue.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// Debounced button-release capture of the switch byte into a FIFO, drained one byte at a time into the UART transmitter.
// Launch is one cycle after a byte reaches an idle queue; tx_active/tx_done throttle draining, and a push into a full FIFO is dropped and flagged.
module uart_tx_queue #(
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     button,
    input  logic [7:0]               switches,
    input  logic                     tx_active,
    input  logic                     tx_done,
    output logic                     tx_dv,
    output logic [7:0]               tx_byte,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SENT = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic           btn_s1;
    logic           btn_s2;
    logic           btn_db;
    logic           btn_db_q;
    logic           push_pulse;
    logic [DBW-1:0] db_cnt;

    logic           push;
    logic           pop;
    logic           wr_en;
    logic           launch;

    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    state_t         state;
    state_t         state_nxt;

    // The button idles high, so every conditioning stage resets to the released level.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_s1     <= 1'b1;
            btn_s2     <= 1'b1;
            btn_db     <= 1'b1;
            btn_db_q   <= 1'b1;
            push_pulse <= 1'b0;
            db_cnt     <= '0;
        end else begin
            btn_s1     <= button;
            btn_s2     <= btn_s1;
            btn_db_q   <= btn_db;
            push_pulse <= btn_db & ~btn_db_q;
            if (btn_s2 != btn_db) begin
                if (db_cnt == DB_LAST) begin
                    btn_db <= btn_s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DBW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign push  = push_pulse & enable;
    assign pop   = launch;
    assign wr_en = push & (~full | pop);
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= switches;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropping enable mid-flight abandons the wait; the transmitter keeps the byte it already has.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (launch) state_nxt = SENT;
            SENT: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (tx_done) begin
                    state_nxt = GAP;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        launch = 1'b0;
        if (state == IDLE && enable && !empty && !tx_active) begin
            launch = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_dv   <= 1'b0;
            tx_byte <= 8'h00;
        end else begin
            tx_dv <= launch;
            if (launch) begin
                tx_byte <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomized bench for uart_tx_queue: a behavioural transmitter plus a queue model of accepted bytes.
module tb_uart_tx_queue;

    localparam int DEPTH = 4;
    localparam int DBC   = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       button;
    logic [7:0] switches;
    logic       tx_active;
    logic       tx_done;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    logic hold_active = 1'b0;
    logic xmit_busy   = 1'b0;
    int   xmit_len    = 0;

    assign tx_active = hold_active | xmit_busy;

    uart_tx_queue #(
        .DEPTH          (DEPTH),
        .DEBOUNCE_CYCLES(DBC)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .button   (button),
        .switches (switches),
        .tx_active(tx_active),
        .tx_done  (tx_done),
        .tx_dv    (tx_dv),
        .tx_byte  (tx_byte),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int dv_count = 0;
    always @(negedge clock) if (tx_dv) dv_count++;

    logic [7:0] exp_all[$];
    logic [7:0] sent_q[$];
    int         sent_cyc[$];
    int         done_cyc[$];
    bit         model_ovf = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    // Transmitter: busy for a while after each launch, then a one-cycle done with active dropped.
    initial begin
        int len;
        tx_done = 1'b0;
        forever begin
            @(negedge clock);
            tx_done = 1'b0;
            if (tx_dv) begin
                sent_q.push_back(tx_byte);
                sent_cyc.push_back(cyc);
                len = (xmit_len > 0) ? xmit_len : int'($urandom_range(2, 6));
                xmit_busy = 1'b1;
                repeat (len) @(negedge clock);
                xmit_busy = 1'b0;
                tx_done = 1'b1;
                done_cyc.push_back(cyc);
            end
        end
    end

    function automatic int model_occ();
        return exp_all.size() - sent_q.size();
    endfunction

    task automatic press(input logic [7:0] b);
        if (enable) begin
            if (model_occ() < DEPTH) exp_all.push_back(b);
            else model_ovf = 1'b1;
        end
        switches = b;
        button = 1'b0;
        repeat ($urandom_range(DBC, DBC + 5)) step();
        button = 1'b1;
        repeat (DBC + 8) step();
    endtask

    task automatic wait_dv(input int target, input string tag);
        int t;
        t = 0;
        while (dv_count < target && t < 200) begin
            step();
            t++;
        end
        check_eq(tag, int'(dv_count >= target), 1);
    endtask

    initial begin
        int c0, t_cnt, t_dv, dv0, s0, byte_at_dv, cnt_at_dv, t;

        reset = 1'b1;
        enable = 1'b1;
        button = 1'b1;
        switches = 8'h00;
        repeat (3) step();
        check_eq("rst_count", int'(count), 0);
        check_eq("rst_empty", int'(empty), 1);
        check_eq("rst_full", int'(full), 0);
        check_eq("rst_overflow", int'(overflow), 0);
        check_eq("rst_tx_dv", int'(tx_dv), 0);
        check_eq("rst_tx_byte", int'(tx_byte), 0);
        reset = 1'b0;
        step();

        // Single press with exact release-to-launch timing.
        exp_all.push_back(8'hA5);
        switches = 8'hA5;
        button = 1'b0;
        repeat ($urandom_range(DBC + 1, DBC + 5)) step();
        button = 1'b1;
        c0 = cyc;
        dv0 = dv_count;
        t_cnt = -1;
        t_dv = -1;
        byte_at_dv = -1;
        cnt_at_dv = -1;
        for (int i = 0; i < DBC + 12; i++) begin
            step();
            if (count == 3'd1 && t_cnt < 0) t_cnt = cyc;
            if (tx_dv && t_dv < 0) begin
                t_dv = cyc;
                byte_at_dv = int'(tx_byte);
                cnt_at_dv = int'(count);
            end
        end
        // sync (2) + debounce (DBC) + edge detect (1) + write (1), then launch one edge later
        check_eq("s1_count_rise", t_cnt - c0, DBC + 4);
        check_eq("s1_dv_time", t_dv - c0, DBC + 5);
        check_eq("s1_byte", byte_at_dv, 8'hA5);
        check_eq("s1_count_at_dv", cnt_at_dv, 0);
        check_eq("s1_dv_pulses", dv_count - dv0, 1);
        repeat (10) step();
        check_eq("s1_byte_held", int'(tx_byte), 8'hA5);

        // Bounces shorter than the debounce window.
        dv0 = dv_count;
        switches = 8'($urandom);
        repeat (3) begin
            button = 1'b0;
            repeat ($urandom_range(1, DBC - 1)) step();
            button = 1'b1;
            repeat ($urandom_range(3, 6)) step();
        end
        repeat (DBC + 8) step();
        check_eq("s2_count", int'(count), 0);
        check_eq("s2_empty", int'(empty), 1);
        check_eq("s2_no_dv", dv_count - dv0, 0);

        // Queue behind a busy transmitter, then drain with done-to-launch spacing.
        dv0 = dv_count;
        s0 = sent_q.size();
        hold_active = 1'b1;
        press(8'h11);
        press(8'h22);
        press(8'h33);
        check_eq("s3_count", int'(count), model_occ());
        check_eq("s3_no_dv", dv_count - dv0, 0);
        hold_active = 1'b0;
        wait_dv(dv0 + 3, "s3_drain_timeout");
        repeat (12) step();
        // done is sampled on the edge after it is driven; launch lands two edges later
        for (int i = 1; i < 3; i++) begin
            if (s0 + i < sent_cyc.size() && s0 + i - 1 < done_cyc.size())
                check_eq("s3_gap", sent_cyc[s0 + i] - done_cyc[s0 + i - 1], 3);
        end

        // Overflow with the drain stalled, then pointer wrap.
        dv0 = dv_count;
        hold_active = 1'b1;
        for (int v = 1; v <= 5; v++) begin
            press(8'(v));
            check_eq("s4_count", int'(count), model_occ());
        end
        check_eq("s4_full", int'(full), 1);
        check_eq("s4_overflow", int'(overflow), int'(model_ovf));
        hold_active = 1'b0;
        wait_dv(dv0 + 4, "s4_drain_timeout");
        repeat (12) step();
        check_eq("s4_drained", int'(count), 0);
        press(8'($urandom));
        press(8'($urandom));
        wait_dv(dv0 + 6, "s4_wrap_timeout");
        repeat (12) step();

        // Enable gating on push.
        dv0 = dv_count;
        enable = 1'b0;
        press(8'($urandom));
        enable = 1'b1;
        repeat (4) step();
        check_eq("s5_gated_count", int'(count), 0);
        check_eq("s5_gated_dv", dv_count - dv0, 0);

        // Enable dropped while a byte is in flight.
        hold_active = 1'b1;
        press(8'($urandom));
        press(8'($urandom));
        check_eq("s5_count2", int'(count), model_occ());
        xmit_len = 25;
        hold_active = 1'b0;
        wait_dv(dv0 + 1, "s5_first_timeout");
        repeat (2) step();
        enable = 1'b0;
        repeat (4) step();
        check_eq("s5_retained", int'(count), 1);
        t = 0;
        while (xmit_busy && t < 60) begin
            step();
            t++;
        end
        repeat (4) step();
        check_eq("s5_no_launch_disabled", dv_count - dv0, 1);
        check_eq("s5_still_retained", int'(count), 1);
        xmit_len = 0;
        enable = 1'b1;
        wait_dv(dv0 + 2, "s5_resume_timeout");
        repeat (12) step();
        check_eq("s5_drained", int'(count), 0);
        check_eq("s5_overflow_sticky", int'(overflow), int'(model_ovf));

        // Reset with a byte in flight and two queued.
        dv0 = dv_count;
        hold_active = 1'b1;
        press(8'($urandom));
        press(8'($urandom));
        press(8'($urandom));
        xmit_len = 30;
        hold_active = 1'b0;
        wait_dv(dv0 + 1, "s6_launch_timeout");
        step();
        check_eq("s6_count_pre", int'(count), 2);
        reset = 1'b1;
        step();
        check_eq("s6_count", int'(count), 0);
        check_eq("s6_empty", int'(empty), 1);
        check_eq("s6_full", int'(full), 0);
        check_eq("s6_tx_dv", int'(tx_dv), 0);
        check_eq("s6_overflow", int'(overflow), 0);
        check_eq("s6_tx_byte", int'(tx_byte), 0);
        reset = 1'b0;
        exp_all = sent_q;
        model_ovf = 1'b0;
        repeat (60) step();
        xmit_len = 0;
        check_eq("s6_no_launch", dv_count - dv0, 1);
        check_eq("s6_count_post", int'(count), 0);

        // Everything launched must match the accepted bytes, in order.
        check_eq("order_len", sent_q.size(), exp_all.size());
        for (int i = 0; i < exp_all.size() && i < sent_q.size(); i++)
            check_eq($sformatf("order_%0d", i), int'(sent_q[i]), int'(exp_all[i]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
